// File: rtl/contador_lector_pkg.sv
// Shared definitions for the counter readout sweeper: parameter defaults,
// fixed port widths and the FSM state encoding.
package contador_lector_pkg;

    localparam int NUM_FIFOS_DEF = 5;
    localparam int CNT_W_DEF     = 5;
    localparam int TIMEOUT_DEF   = 8;
    localparam int IDX_W         = 3;
    localparam int TOTAL_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_IDLE  = 3'd1,
        ST_REQ        = 3'd2,
        ST_WAIT_VALID = 3'd3,
        ST_DONE       = 3'd4
    } state_e;

    // Timer must be able to hold TIMEOUT-1; never narrower than one bit.
    function automatic int timer_width(input int timeout);
        if (timeout <= 2) begin
            return 1;
        end
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/contador_lector_if.sv
// Read-request handshake between the sweeper (master) and the counter block (slave).
interface contador_lector_if
    import contador_lector_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic             req;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] data_in;
    logic             valid_in;

    modport master (
        output req,
        output idx,
        input  data_in,
        input  valid_in
    );

    modport slave (
        input  req,
        input  idx,
        output data_in,
        output valid_in
    );

endinterface

// File: rtl/contador_lector_tabla.sv
// Captured-count table for the readout sweep, with an asynchronous read port
// that returns zero for indices beyond the table.
module lector_tabla
    import contador_lector_pkg::*;
#(
    parameter int NUM_FIFOS = NUM_FIFOS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [CNT_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0] rd_sel_i,
    output logic [CNT_W-1:0] rd_data_o
);

    logic [CNT_W-1:0] table_q [NUM_FIFOS];
    logic [CNT_W-1:0] table_d [NUM_FIFOS];

    // Clear wins over a write; the two never coincide in the sweeper anyway.
    always_comb begin
        for (int i = 0; i < NUM_FIFOS; i++) begin
            table_d[i] = table_q[i];
        end
        if (clear_i) begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                table_d[i] = '0;
            end
        end else if (wr_en_i) begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                if (wr_idx_i == IDX_W'(i)) begin
                    table_d[i] = wr_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (rd_sel_i == IDX_W'(i)) begin
                rd_data_o = table_q[i];
            end
        end
    end

endmodule

// File: rtl/contador_lector.sv
// Counter readout sweeper: on start, waits for the FIFOs to drain, then reads every
// counter in turn, accumulating a total and flagging a timeout if a counter never answers.
module contador_lector
    import contador_lector_pkg::*;
#(
    parameter int NUM_FIFOS = NUM_FIFOS_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     idle,
    contador_lector_if.master        bus,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [TOTAL_W-1:0]       total,
    input  logic [IDX_W-1:0]         rd_sel,
    output logic [CNT_W-1:0]         rd_data
);

    localparam int TMR_W = timer_width(TIMEOUT);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic               error_q, error_d;

    logic last_idx;
    logic timer_exp;
    logic req_s;
    logic tbl_clr;
    logic tbl_wr;

    assign last_idx  = (idx_q == IDX_W'(NUM_FIFOS - 1));
    assign timer_exp = (timer_q == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            total_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            total_q <= total_d;
            error_q <= error_d;
        end
    end

    // A valid_in on the very cycle the timer expires still counts as an answer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (start) state_d = ST_WAIT_IDLE;
            ST_WAIT_IDLE:  if (idle) state_d = ST_REQ;
            ST_REQ:        state_d = ST_WAIT_VALID;
            ST_WAIT_VALID: begin
                if (bus.valid_in) begin
                    state_d = last_idx ? ST_DONE : ST_REQ;
                end else if (timer_exp) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        timer_d = timer_q;
        total_d = total_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    total_d = '0;
                    error_d = 1'b0;
                end
            end
            ST_WAIT_IDLE: begin
                if (idle) begin
                    idx_d = '0;
                end
            end
            ST_REQ: begin
                timer_d = '0;
            end
            ST_WAIT_VALID: begin
                if (bus.valid_in) begin
                    total_d = total_q + TOTAL_W'(bus.data_in);
                    if (!last_idx) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (timer_exp) begin
                    error_d = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        req_s   = (state_q == ST_REQ);
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        tbl_clr = (state_q == ST_IDLE) && start;
        tbl_wr  = (state_q == ST_WAIT_VALID) && bus.valid_in;
    end

    assign bus.req = req_s;
    assign bus.idx = idx_q;
    assign total   = total_q;
    assign error   = error_q;

    lector_tabla #(
        .NUM_FIFOS (NUM_FIFOS),
        .CNT_W     (CNT_W)
    ) u_tabla (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (tbl_clr),
        .wr_en_i   (tbl_wr),
        .wr_idx_i  (idx_q),
        .wr_data_i (bus.data_in),
        .rd_sel_i  (rd_sel),
        .rd_data_o (rd_data)
    );

endmodule

// File: tb/tb_contador_lector.sv
// Scoreboard bench for contador_lector: stimulus pushes expected requests and done
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_contador_lector;
    import contador_lector_pkg::*;

    localparam int NUM_FIFOS = NUM_FIFOS_DEF;
    localparam int CNT_W     = CNT_W_DEF;
    localparam int TIMEOUT   = TIMEOUT_DEF;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               idle;
    logic               busy;
    logic               done;
    logic               error;
    logic [TOTAL_W-1:0] total;
    logic [IDX_W-1:0]   rd_sel;
    logic [CNT_W-1:0]   rd_data;

    contador_lector_if #(.CNT_W(CNT_W)) bus ();

    contador_lector #(
        .NUM_FIFOS (NUM_FIFOS),
        .CNT_W     (CNT_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .idle    (idle),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .total   (total),
        .rd_sel  (rd_sel),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int cyc;
    } req_exp_t;

    typedef struct {
        int total;
        int err;
        int lat;
    } done_exp_t;

    req_exp_t  reqQ[$];
    done_exp_t doneQ[$];
    req_exp_t  reqE;
    done_exp_t doneE;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycleCnt    = 0;
    int startCycle  = 0;
    int counts   [NUM_FIFOS];
    int expTable [NUM_FIFOS];
    int silentIdx   = -1;
    bit strayMode   = 1'b0;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Model of a sweep: request k appears 2k+2 cycles after start (plus idle delay);
    // a silent counter costs TIMEOUT wait cycles before DONE.
    task automatic pushSweep(input int silent, input int delay, input bit expectDone);
        int tot = 0;
        for (int k = 0; k < NUM_FIFOS; k++) begin
            reqQ.push_back(req_exp_t'{k, 2 * k + 2 + delay});
            if (k == silent) begin
                for (int j = k; j < NUM_FIFOS; j++) expTable[j] = 0;
                if (expectDone) doneQ.push_back(done_exp_t'{tot, 1, 2 * k + 3 + TIMEOUT + delay});
                return;
            end
            expTable[k] = counts[k];
            tot += counts[k];
        end
        if (expectDone) doneQ.push_back(done_exp_t'{tot, 0, 2 * NUM_FIFOS + 2 + delay});
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1 start = 1'b1;
        startCycle = cycleCnt;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: got no done pulse, expected one within 200 cycles", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkTable(input string name);
        for (int k = 0; k < NUM_FIFOS; k++) begin
            rd_sel = IDX_W'(k);
            #1 checkOutput($sformatf("%s table[%0d]", name, k), 32'(rd_data), expTable[k]);
        end
    endtask

    task automatic checkDrained(input string name);
        checkOutput({name, " req queue left"}, reqQ.size(), 0);
        checkOutput({name, " done queue left"}, doneQ.size(), 0);
    endtask

    // Monitor: every req or done the DUT shows must match the next expected entry.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.req === 1'b1) begin
                if (reqQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected req: got req for idx %0d, expected none", bus.idx);
                end else begin
                    reqE = reqQ.pop_front();
                    checkOutput("req idx", 32'(bus.idx), reqE.idx);
                    checkOutput("req cycle", cycleCnt - startCycle, reqE.cyc);
                end
            end
            if (done === 1'b1) begin
                if (doneQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected done: got done, expected none");
                end else begin
                    doneE = doneQ.pop_front();
                    checkOutput("done total", 32'(total), doneE.total);
                    checkOutput("done error", 32'(error), doneE.err);
                    checkOutput("done latency", cycleCnt - startCycle, doneE.lat);
                end
            end
        end
    end

    // Counter block model: answers each request one cycle later, optionally with a
    // junk valid during the request cycle, and stays silent for silentIdx.
    initial begin
        int ri;
        forever begin
            @(negedge clk);
            if (bus.req === 1'b1 && reset === 1'b0) begin
                ri = int'(bus.idx);
                if (strayMode) begin
                    bus.valid_in = 1'b1;
                    bus.data_in  = '1;
                end
                @(posedge clk);
                #1;
                if (ri != silentIdx && ri < NUM_FIFOS) begin
                    bus.valid_in = 1'b1;
                    bus.data_in  = CNT_W'(counts[ri]);
                end else begin
                    bus.valid_in = 1'b0;
                end
                @(posedge clk);
                #1 bus.valid_in = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        idle         = 1'b1;
        rd_sel       = '0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        counts       = '{3, 0, 7, 31, 1};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset done", 32'(done), 0);
        checkOutput("reset error", 32'(error), 0);
        checkOutput("reset total", 32'(total), 0);
        checkOutput("reset req", 32'(bus.req), 0);
        checkOutput("reset idx", 32'(bus.idx), 0);
        checkOutput("reset rd_data", 32'(rd_data), 0);
        reset = 1'b0;

        $display("[TB] basic sweep");
        pushSweep(-1, 0, 1'b1);
        applyStimulus();
        waitDone("basic");
        checkOutput("basic total", 32'(total), 42);
        checkOutput("basic error", 32'(error), 0);
        checkOutput("basic busy after done", 32'(busy), 0);
        checkTable("basic");
        for (int s = 5; s < 8; s++) begin
            rd_sel = IDX_W'(s);
            #1 checkOutput($sformatf("rd_sel %0d out of range", s), 32'(rd_data), 0);
        end
        rd_sel = 3'd3;
        #1 checkOutput("rd_sel 3 after basic", 32'(rd_data), 31);
        checkDrained("basic");
        repeat (5) @(posedge clk);
        #1;
        checkOutput("basic total held", 32'(total), 42);
        checkOutput("basic rd_data held", 32'(rd_data), 31);

        $display("[TB] sweep waits for idle");
        idle = 1'b0;
        pushSweep(-1, 10, 1'b1);
        applyStimulus();
        checkOutput("busy in WAIT_IDLE", 32'(busy), 1);
        repeat (10) @(posedge clk);
        #1 idle = 1'b1;
        waitDone("idle wait");
        checkOutput("idle wait total", 32'(total), 42);
        checkDrained("idle wait");

        $display("[TB] timeout at idx 2");
        counts    = '{5, 9, 7, 31, 1};
        silentIdx = 2;
        pushSweep(2, 0, 1'b1);
        applyStimulus();
        waitDone("timeout");
        checkOutput("timeout error", 32'(error), 1);
        checkOutput("timeout total", 32'(total), 14);
        checkTable("timeout");
        checkDrained("timeout");
        silentIdx = -1;

        $display("[TB] restart and stray valid ignored");
        counts    = '{3, 0, 7, 31, 1};
        strayMode = 1'b1;
        pushSweep(-1, 0, 1'b1);
        applyStimulus();
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone("stray");
        strayMode = 1'b0;
        checkOutput("stray total", 32'(total), 42);
        checkOutput("stray error cleared", 32'(error), 0);
        checkTable("stray");
        checkDrained("stray");

        $display("[TB] reset mid-sweep");
        rd_sel    = '0;
        silentIdx = 3;
        pushSweep(3, 0, 1'b0);
        applyStimulus();
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 100 && !hit; i++) begin
                @(negedge clk);
                if (bus.req === 1'b1 && bus.idx === 3'd3) hit = 1'b1;
            end
            checkOutput("reached idx 3", 32'(hit), 1);
        end
        @(posedge clk);
        #2;
        checkOutput("pre-reset total", 32'(total), 10);
        reset = 1'b1;
        #1;
        checkOutput("async reset req", 32'(bus.req), 0);
        checkOutput("async reset idx", 32'(bus.idx), 0);
        checkOutput("async reset busy", 32'(busy), 0);
        checkOutput("async reset done", 32'(done), 0);
        checkOutput("async reset total", 32'(total), 0);
        checkOutput("async reset table[0]", 32'(rd_data), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        silentIdx = -1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("no restart without start", 32'(busy), 0);
        checkDrained("reset");

        $display("[TB] clean sweep after reset");
        pushSweep(-1, 0, 1'b1);
        applyStimulus();
        waitDone("post reset");
        checkOutput("post reset total", 32'(total), 42);
        checkOutput("post reset error", 32'(error), 0);
        checkTable("post reset");
        checkDrained("post reset");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/contador_lector.md
CONTADOR_LECTOR -- requirements
Module: contador_lector

Interface
REQ-001 Parameter NUM_FIFOS, default 5: number of counters swept, indices 0..NUM_FIFOS-1.
REQ-002 Parameter CNT_W, default 5: width of each count word.
REQ-003 Parameter TIMEOUT, default 8: maximum number of WAIT_VALID cycles allowed per index.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request for a full readout sweep.
REQ-007 idle  input  1  high when all FIFOs are drained.
REQ-008 data_in  input  CNT_W  count returned by the counter block.
REQ-009 valid_in  input  1  qualifies data_in.
REQ-010 req  output  1  read request to the counter block.
REQ-011 idx  output  3  counter index being requested.
REQ-012 busy  output  1  high from sweep acceptance until DONE completes.
REQ-013 done  output  1  one-cycle pulse at sweep end.
REQ-014 error  output  1  sticky timeout flag for the last sweep.
REQ-015 total  output  8  sum of all counts captured in the last sweep.
REQ-016 rd_sel  input  3  asynchronous read select into the captured-count table.
REQ-017 rd_data  output  CNT_W  captured count at rd_sel; returns 0 when rd_sel >= NUM_FIFOS.

Function
REQ-018 The FSM SHALL have the states IDLE, WAIT_IDLE, REQ, WAIT_VALID and DONE.
REQ-019 IDLE: start=1 -> WAIT_IDLE, and total, error and the count table SHALL clear on that same edge.
REQ-020 WAIT_IDLE: idle=1 -> REQ with idx=0; otherwise the FSM SHALL remain in WAIT_IDLE indefinitely.
REQ-021 REQ: req=1 for exactly one cycle, then -> WAIT_VALID with the timeout timer set to 0.
REQ-022 WAIT_VALID: req=0, idx held, and the timer SHALL increment each cycle that valid_in=0.
REQ-023 WAIT_VALID with valid_in=1: table[idx] <= data_in, total <= total + data_in; then if idx==NUM_FIFOS-1 -> DONE, else idx+1 and -> REQ.
REQ-024 Timeout occurs when the timer reaches TIMEOUT-1 with valid_in=0: error <= 1, table[idx] stays 0, and the FSM SHALL go -> DONE, aborting the remaining indices.
REQ-025 DONE: done=1 for one cycle, then -> IDLE; busy SHALL be 0 only in IDLE.
REQ-026 start SHALL be ignored in every state except IDLE.
REQ-027 valid_in SHALL be ignored outside WAIT_VALID, including during the REQ cycle itself.
REQ-028 idle SHALL be sampled only in WAIT_IDLE; a deassertion after that point SHALL NOT affect the sweep.
REQ-029 total SHALL be 8 bits wide; the maximum sum is 5*31=155, so overflow cannot occur at default parameters.
REQ-030 Minimum sweep latency SHALL be 2*NUM_FIFOS+2 cycles from start to done when idle=1 and valid_in follows req by one cycle.
REQ-031 Outputs total, error and the table SHALL hold their values after DONE until the next accepted start.

Reset
REQ-032 Asserting reset SHALL immediately force: state=IDLE, req=0, idx=0, busy=0, done=0, error=0, total=0, table all 0, timer=0.
REQ-033 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; the first sweep after release SHALL require a new start.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding and the NUM_FIFOS, CNT_W and TIMEOUT defaults, used by both RTL and bench.
REQ-035 The count table plus rd_sel mux SHALL be one sub-module, lector_tabla; the FSM, timer and accumulator SHALL be in the top module.
REQ-036 The top module SHALL be synthesizable and equivalence-checkable against a synthesized netlist named contador_lector_synth.

Verification
REQ-037 Counts 3,0,7,31,1; idle=1; start pulse -> req/idx pulses 0..4; table=3,0,7,31,1; total=42; done at cycle 12; error=0.
REQ-038 start with idle=0 for 10 cycles, then idle=1 -> no req during the idle=0 cycles; first req one cycle after idle rises.
REQ-039 valid_in never asserted for idx=2 -> error=1 after 8 WAIT_VALID cycles; table[3], table[4] = 0; total = sum of idx 0 and 1; done pulse issued.
REQ-040 start re-pulsed during WAIT_VALID, plus a stray valid_in during a REQ cycle -> both ignored; results identical to REQ-037.
REQ-041 reset asserted at idx=3 in WAIT_VALID -> all outputs 0 within the same cycle; no done pulse; a following start runs a clean sweep.
REQ-042 rd_sel=5,6,7 -> rd_data=0; rd_sel=3 after REQ-037 -> rd_data=31.
